// File: rtl/packing_return_fifo.sv
// Byte-packing FIFO: accepts 0..IN_BYTES bytes per cycle and returns OUT_BYTES-wide words with keep/last framing.
// Optional byte statistics output enabled by defining PACKING_RETURN_FIFO_STATS_EN.
module packing_return_fifo #(
    parameter int IN_BYTES   = 16,
    parameter int OUT_BYTES  = 8,
    parameter int FIFO_DEPTH = 64
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [IN_BYTES*8-1:0]         dataIn,
    input  logic [$clog2(IN_BYTES)+1:0]   dataInBytesValid,
    output logic                          dataInShift,
    input  logic                          endOfStream,
    output logic [OUT_BYTES*8-1:0]        dataOut,
    output logic [OUT_BYTES-1:0]          dataOutKeep,
    output logic                          dataOutLast,
    output logic                          dataOutValid,
    input  logic                          dataOutReady,
    output logic [$clog2(FIFO_DEPTH):0]   fifoCount
`ifdef PACKING_RETURN_FIFO_STATS_EN
    ,
    output logic [31:0]                   bytesOut
`endif
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int NW = $clog2(IN_BYTES) + 1;
    localparam int KW = $clog2(OUT_BYTES) + 1;

    localparam logic [NW:0]   IN_BYTES_V  = IN_BYTES[NW:0];
    localparam logic [NW-1:0] IN_BYTES_N  = IN_BYTES[NW-1:0];
    localparam logic [CW-1:0] OUT_BYTES_C = OUT_BYTES[CW-1:0];
    localparam logic [KW-1:0] OUT_BYTES_K = OUT_BYTES[KW-1:0];
    localparam logic [CW-1:0] DEPTH_C     = FIFO_DEPTH[CW-1:0];

    typedef enum logic [1:0] {
        STREAM    = 2'd0,
        FLUSH     = 2'd1,
        LAST_WAIT = 2'd2
    } state_t;

    state_t            state;
    logic [7:0]        mem [FIFO_DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;

    logic [NW-1:0]     n;
    logic [CW-1:0]     free;
    logic              load_slot;
    logic              load;
    logic [KW-1:0]     take;
    logic              take_last;
    logic [CW-1:0]     push;
    logic [CW-1:0]     pop;
    logic [OUT_BYTES*8-1:0] word;

    function automatic logic [NW-1:0] clamp_offer(input logic [NW:0] v);
        if (v > IN_BYTES_V)
            return IN_BYTES_N;
        return v[NW-1:0];
    endfunction

    function automatic logic [KW-1:0] flush_take(input logic [CW-1:0] c);
        if (c >= OUT_BYTES_C)
            return OUT_BYTES_K;
        return c[KW-1:0];
    endfunction

    function automatic logic [OUT_BYTES-1:0] keep_mask(input logic [KW-1:0] k);
        logic [OUT_BYTES-1:0] m;
        m = '0;
        for (int i = 0; i < OUT_BYTES; i++)
            m[i] = (i < int'(k));
        return m;
    endfunction

    // Accept/pop decisions use the count at the start of the cycle, so freshly written bytes are never read the same cycle.
    always_comb begin
        n           = clamp_offer(dataInBytesValid);
        free        = DEPTH_C - fifoCount;
        dataInShift = (state == STREAM) && (n != '0) && (free >= CW'(n));
        load_slot   = !dataOutValid || dataOutReady;
        load        = 1'b0;
        take        = '0;
        take_last   = 1'b0;
        case (state)
            STREAM: begin
                if (fifoCount >= OUT_BYTES_C) begin
                    take = OUT_BYTES_K;
                    load = load_slot;
                end
            end
            FLUSH: begin
                take      = flush_take(fifoCount);
                take_last = (fifoCount <= OUT_BYTES_C);
                load      = load_slot;
            end
            default: ;
        endcase
        push = dataInShift ? CW'(n) : '0;
        pop  = load ? CW'(take) : '0;
    end

    always_comb begin
        word = '0;
        for (int i = 0; i < OUT_BYTES; i++) begin
            if (i < int'(take))
                word[i*8 +: 8] = mem[rd_ptr + PW'(i)];
        end
    end

    // Byte storage carries no reset; only pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (dataInShift) begin
            for (int i = 0; i < IN_BYTES; i++) begin
                if (i < int'(n))
                    mem[wr_ptr + PW'(i)] <= dataIn[i*8 +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= STREAM;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            fifoCount    <= '0;
            dataOut      <= '0;
            dataOutKeep  <= '0;
            dataOutLast  <= 1'b0;
            dataOutValid <= 1'b0;
        end else begin
            if (dataInShift)
                wr_ptr <= wr_ptr + PW'(n);
            if (load)
                rd_ptr <= rd_ptr + PW'(take);
            fifoCount <= fifoCount + push - pop;

            if (load) begin
                dataOut      <= word;
                dataOutKeep  <= keep_mask(take);
                dataOutLast  <= take_last;
                dataOutValid <= 1'b1;
            end else if (dataOutValid && dataOutReady) begin
                dataOutValid <= 1'b0;
            end

            case (state)
                STREAM: begin
                    if (endOfStream && (dataInShift || n == '0))
                        state <= FLUSH;
                end
                FLUSH: begin
                    if (load && take_last)
                        state <= LAST_WAIT;
                end
                LAST_WAIT: begin
                    if (dataOutValid && dataOutReady && dataOutLast)
                        state <= STREAM;
                end
                default: state <= STREAM;
            endcase
        end
    end

`ifdef PACKING_RETURN_FIFO_STATS_EN
    logic stats_clr;

    // The counter shows the full stream total for one cycle after the last word, then returns to zero.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bytesOut  <= '0;
            stats_clr <= 1'b0;
        end else begin
            stats_clr <= dataOutValid && dataOutReady && dataOutLast;
            if (stats_clr)
                bytesOut <= '0;
            else if (dataOutValid && dataOutReady)
                bytesOut <= bytesOut + 32'($countones(dataOutKeep));
        end
    end
`endif

endmodule

// File: tb/tb_packing_return_fifo.sv
// Scoreboard bench for packing_return_fifo: a byte-queue model predicts framed output words.
module tb_packing_return_fifo;

    logic         clk;
    logic         reset;
    logic [127:0] dataIn;
    logic [5:0]   dataInBytesValid;
    logic         dataInShift;
    logic         endOfStream;
    logic [63:0]  dataOut;
    logic [7:0]   dataOutKeep;
    logic         dataOutLast;
    logic         dataOutValid;
    logic         dataOutReady;
    logic [6:0]   fifoCount;

    packing_return_fifo dut (
        .clk              (clk),
        .reset            (reset),
        .dataIn           (dataIn),
        .dataInBytesValid (dataInBytesValid),
        .dataInShift      (dataInShift),
        .endOfStream      (endOfStream),
        .dataOut          (dataOut),
        .dataOutKeep      (dataOutKeep),
        .dataOutLast      (dataOutLast),
        .dataOutValid     (dataOutValid),
        .dataOutReady     (dataOutReady),
        .fifoCount        (fifoCount)
    );

    typedef struct packed {
        logic [63:0] d;
        logic [7:0]  k;
        logic        l;
    } word_t;

    word_t      exp_q[$];
    logic [7:0] pend[$];
    int         hs_q[$];
    int         vectors     = 0;
    int         miscompares = 0;
    int         stall_cnt   = 0;
    int         cyc         = 0;
    int         ready_mode  = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running, required completion");
        $fatal(1);
    end

    task automatic check(input string what, input logic [127:0] act, input logic [127:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0h required %0h", what, act, req);
        end
    endtask

    task automatic note_fail(input string what);
        vectors++;
        miscompares++;
        $display("FAIL %s: wait bound expired, required DUT response", what);
    endtask

    // Reference model: stream bytes are framed into OUT_BYTES chunks; the final chunk carries last.
    task automatic push_word(input int cnt, input bit last);
        word_t w;
        w.d = '0;
        for (int i = 0; i < cnt; i++)
            w.d[i*8 +: 8] = pend.pop_front();
        w.k = 8'((16'd1 << cnt) - 16'd1);
        w.l = last;
        exp_q.push_back(w);
    endtask

    task automatic model_accept(input logic [127:0] d, input int n, input bit eos);
        for (int i = 0; i < n; i++)
            pend.push_back(d[i*8 +: 8]);
        while (pend.size() > 8 || (pend.size() == 8 && !eos))
            push_word(8, 1'b0);
        if (eos)
            push_word(pend.size(), 1'b1);
    endtask

    task automatic offer_try(input int nb, input bit eos, input int maxwait, output bit acc);
        int n;
        int waitc;
        logic [127:0] d;
        n = (nb > 16) ? 16 : nb;
        d = {$urandom, $urandom, $urandom, $urandom};
        acc = 1'b0;
        waitc = 0;
        @(negedge clk);
        dataIn = d;
        dataInBytesValid = 6'(nb);
        endOfStream = eos;
        forever begin
            #4;
            if (n == 0) begin
                acc = 1'b1;
                if (eos)
                    push_word(pend.size(), 1'b1);
                break;
            end
            if (dataInShift) begin
                acc = 1'b1;
                model_accept(d, n, eos);
                break;
            end
            stall_cnt++;
            waitc++;
            if (waitc >= maxwait)
                break;
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        dataInBytesValid = '0;
        endOfStream = 1'b0;
    endtask

    task automatic offer(input int nb, input bit eos);
        bit acc;
        offer_try(nb, eos, 3000, acc);
        if (!acc)
            note_fail("offer_accept");
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while ((exp_q.size() != 0 || dataOutValid) && t < 5000) begin
            @(negedge clk);
            #3;
            t++;
        end
        if (t >= 5000)
            note_fail("drain");
        @(negedge clk);
    endtask

    always @(negedge clk) begin
        case (ready_mode)
            0:       dataOutReady = 1'b1;
            1:       dataOutReady = 1'b0;
            default: dataOutReady = ($urandom_range(0, 3) != 0);
        endcase
    end

    // Monitor: compares every handshaken word against the queue and checks held words stay put.
    initial begin
        bit          held;
        logic [72:0] held_w;
        word_t       e;
        held = 1'b0;
        held_w = '0;
        forever begin
            @(negedge clk);
            #3;
            if (!reset) begin
                held = 1'b0;
            end else begin
                if (held)
                    check("hold_stable", 128'({dataOutValid, dataOut, dataOutKeep, dataOutLast}),
                          128'({1'b1, held_w}));
                if (dataOutValid && dataOutReady) begin
                    hs_q.push_back(cyc);
                    if (exp_q.size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL unexpected_word: got %0h required no word",
                                 {dataOut, dataOutKeep, dataOutLast});
                    end else begin
                        e = exp_q.pop_front();
                        check("word", 128'({dataOut, dataOutKeep, dataOutLast}), 128'(e));
                    end
                    held = 1'b0;
                end else if (dataOutValid) begin
                    held = 1'b1;
                    held_w = {dataOut, dataOutKeep, dataOutLast};
                end else begin
                    held = 1'b0;
                end
            end
        end
    end

    initial begin
        bit acc;
        int t;
        int len;
        int nb;
        reset = 1'b0;
        dataIn = '0;
        dataInBytesValid = '0;
        endOfStream = 1'b0;
        dataOutReady = 1'b1;
        repeat (3) @(negedge clk);
        #2;
        check("reset_valid", 128'(dataOutValid), 128'(0));
        check("reset_count", 128'(fifoCount), 128'(0));
        check("reset_keep",  128'(dataOutKeep), 128'(0));
        check("reset_last",  128'(dataOutLast), 128'(0));
        check("reset_data",  128'(dataOut), 128'(0));
        @(negedge clk);
        reset = 1'b1;

        // Empty stream yields one empty last word.
        offer(0, 1);
        wait_idle();

        // 5+5+5 bytes with end-of-stream on the third; extra end-of-stream while flushing is ignored.
        offer(5, 0);
        offer(5, 0);
        offer(5, 1);
        ready_mode = 1;
        repeat (3) begin
            @(negedge clk);
            dataInBytesValid = '0;
            endOfStream = 1'b1;
        end
        @(negedge clk);
        endOfStream = 1'b0;
        ready_mode = 0;
        wait_idle();

        // One 16-byte offer with end-of-stream: exactly two full words.
        offer(16, 1);
        wait_idle();

        // Continuous 16-byte offers: eight back-to-back words, no input stalls.
        hs_q.delete();
        stall_cnt = 0;
        repeat (4) offer(16, 0);
        check("burst_stall", 128'(stall_cnt), 128'(0));
        t = 0;
        while (hs_q.size() < 8 && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (hs_q.size() < 8)
            note_fail("burst_words");
        else
            check("burst_gap", 128'(hs_q[7] - hs_q[0]), 128'(7));
        t = 0;
        while (fifoCount != 0 && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (fifoCount != 0)
            note_fail("burst_empty");
        offer(0, 1);
        wait_idle();

        // Fill to capacity with output stalled, then drain across the pointer wrap.
        ready_mode = 1;
        for (int k = 0; k < 20 && fifoCount != 7'd64; k++)
            offer(8, 0);
        check("full_count", 128'(fifoCount), 128'(64));
        offer_try(1, 0, 5, acc);
        check("full_no_shift", 128'(acc), 128'(0));
        ready_mode = 0;
        for (int k = 0; k < 10; k++)
            offer($urandom_range(1, 16), 0);
        offer($urandom_range(1, 16), 1);
        wait_idle();

        // Asynchronous reset while a flush word is held.
        ready_mode = 1;
        offer(16, 1);
        repeat (3) @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        check("rst_mid_valid", 128'(dataOutValid), 128'(0));
        check("rst_mid_count", 128'(fifoCount), 128'(0));
        check("rst_mid_keep",  128'(dataOutKeep), 128'(0));
        exp_q.delete();
        pend.delete();
        ready_mode = 0;
        @(negedge clk);
        reset = 1'b1;
        offer(5, 0);
        offer(5, 0);
        offer(6, 1);
        wait_idle();

        // Randomized streams with random backpressure and over-range offers.
        ready_mode = 2;
        for (int s = 0; s < 8; s++) begin
            len = $urandom_range(3, 25);
            for (int k = 0; k < len; k++) begin
                nb = ($urandom_range(0, 9) == 0) ? 40 : $urandom_range(0, 18);
                offer(nb, 0);
            end
            if (pend.size() != 0 && $urandom_range(0, 1) == 1)
                offer(0, 1);
            else
                offer($urandom_range(1, 16), 1);
            wait_idle();
        end

        check("final_queue", 128'(exp_q.size()), 128'(0));
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
